// File: rtl/filter_select_if.sv
// Key inputs and filter-selection outputs shared by the selection FSM and its host.
interface filter_select_if;
   logic [3:0] key;
   logic [1:0] filter_type;
   logic       filter_changed;
   logic       locked;

   modport master (output key, input filter_type, input filter_changed, input locked);
   modport slave  (input key, output filter_type, output filter_changed, output locked);
endinterface

// File: rtl/filter_select_fsm.sv
// Push-button conditioning (sync, debounce, press edge) and video filter selection FSM.
//
// state       | meaning
// ST_UNLOCKED | CLEAR/NEXT/PREV presses update filter_type
// ST_LOCKED   | selection frozen; only LOCK is honoured
module filter_select_fsm #(
   parameter  int DEBOUNCE_CYCLES = 1_000_000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic           clk,
   input  logic           rst_n,
   filter_select_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] r_db;
   logic [3:0] r_db_prev;
   logic [3:0] r_press;

   state_t     r_state;
   state_t     w_state_nx;
   logic [1:0] r_filter_type;
   logic [1:0] w_filter_type_nx;
   logic       r_changed;
   logic       w_changed_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= bus.key;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;

      // Any cycle where the synced level agrees with the accepted level restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt   <= '0;
            r_db[g] <= 1'b1;
         end else if (r_sync2[g] == r_db[g]) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_db[g] <= r_sync2[g];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db_prev <= 4'h0;
         r_press   <= 4'h0;
      end else begin
         r_db_prev <= r_db;
         r_press   <= r_db_prev & ~r_db;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_UNLOCKED;
         r_filter_type <= 2'd0;
         r_changed     <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_filter_type <= w_filter_type_nx;
         r_changed     <= w_changed_nx;
      end
   end

   // Priority LOCK > CLEAR > NEXT > PREV; losing pulses are simply dropped.
   always_comb begin
      w_state_nx       = r_state;
      w_filter_type_nx = r_filter_type;
      if (r_press[3]) begin
         w_state_nx = (r_state == ST_LOCKED) ? ST_UNLOCKED : ST_LOCKED;
      end else if (r_state == ST_UNLOCKED) begin
         if (r_press[2]) begin
            w_filter_type_nx = 2'd0;
         end else if (r_press[0]) begin
            w_filter_type_nx = r_filter_type + 2'd1;
         end else if (r_press[1]) begin
            w_filter_type_nx = r_filter_type - 2'd1;
         end
      end
      w_changed_nx = (w_filter_type_nx != r_filter_type);
   end

   assign bus.filter_type    = r_filter_type;
   assign bus.filter_changed = r_changed;
   assign bus.locked         = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_filter_select_fsm.sv
// Scenario bench for filter_select_fsm with a behavioural selection model.
module tb_filter_select_fsm;

   localparam int D = 16;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   m_ft;
   int   m_lock;

   filter_select_if bus ();

   filter_select_fsm #(.DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: apply the press mask using the documented priority and lock rules.
   task automatic model_apply(input logic [3:0] m);
      if (m[3])           m_lock = 1 - m_lock;
      else if (m_lock == 0) begin
         if (m[2])      m_ft = 0;
         else if (m[0]) m_ft = (m_ft + 1) % 4;
         else if (m[1]) m_ft = (m_ft + 3) % 4;
      end
   endtask

   // Holds ~mask low for 'hold' edges starting at edge N (k=0) and records outputs around N+D+3.
   task automatic drive_press(input logic [3:0] mask, input int hold,
                              output logic [1:0] ft_pre, output logic [1:0] ft_at,
                              output logic chg_pre, output logic chg_at, output logic chg_post,
                              output logic lk_at, output int pulses, output int late_moves);
      int         total;
      logic [1:0] ft_hold;
      total      = hold + D + 8;
      pulses     = 0;
      late_moves = 0;
      ft_hold    = 2'd0;
      @(posedge clk); #1;
      bus.key = ~mask;
      for (int k = 0; k < total; k++) begin
         @(posedge clk); #1;
         if (bus.filter_changed) pulses++;
         if (k == D + 2) begin ft_pre = bus.filter_type; chg_pre = bus.filter_changed; end
         if (k == D + 3) begin
            ft_at = bus.filter_type; chg_at = bus.filter_changed; lk_at = bus.locked;
            ft_hold = bus.filter_type;
         end
         if (k == D + 4) chg_post = bus.filter_changed;
         if (k > D + 3 && bus.filter_type !== ft_hold) late_moves++;
         if (k == hold - 1) bus.key = 4'hF;
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      n_checks++;
      if ({bus.filter_type, bus.filter_changed, bus.locked} !== 4'b0000)
         $display("FAIL reset_values: got ft=%0d chg=%0b lk=%0b want 0/0/0",
                  bus.filter_type, bus.filter_changed, bus.locked);
      else n_pass++;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if ({bus.filter_type, bus.filter_changed, bus.locked} !== 4'b0000) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL idle_quiet: got %0d disturbed cycles want 0", bad);
      else n_pass++;
   endtask

   task automatic test_latency();
      logic [1:0] fp, fa; logic cp, ca, cq, la; int p, lm;
      drive_press(4'b0001, 40, fp, fa, cp, ca, cq, la, p, lm);
      model_apply(4'b0001);
      n_checks++;
      if (fp !== 2'd0 || cp !== 1'b0) $display("FAIL latency_early: got ft=%0d chg=%0b at N+%0d want 0/0", fp, cp, D + 2);
      else n_pass++;
      n_checks++;
      if (fa !== 2'(m_ft) || ca !== 1'b1) $display("FAIL latency_land: got ft=%0d chg=%0b at N+%0d want %0d/1", fa, ca, D + 3, m_ft);
      else n_pass++;
      n_checks++;
      if (cq !== 1'b0 || p !== 1 || lm !== 0) $display("FAIL no_repeat: got post=%0b pulses=%0d moves=%0d want 0/1/0", cq, p, lm);
      else n_pass++;
   endtask

   task automatic test_next_prev();
      logic [3:0] seq [6];
      logic [1:0] fp, fa; logic cp, ca, cq, la; int p, lm, want_p, old;
      seq = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      for (int i = 0; i < 6; i++) begin
         old = m_ft;
         drive_press(seq[i], $urandom_range(D + 5, D + 30), fp, fa, cp, ca, cq, la, p, lm);
         model_apply(seq[i]);
         want_p = (m_ft != old) ? 1 : 0;
         n_checks++;
         if (fa !== 2'(m_ft)) $display("FAIL step%0d_ft: got %0d want %0d", i, fa, m_ft);
         else n_pass++;
         n_checks++;
         if (p !== want_p) $display("FAIL step%0d_pulses: got %0d want %0d", i, p, want_p);
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      logic [1:0] ft0, fp, fa; logic cp, ca, cq, la; int p, lm, moves;
      ft0 = bus.filter_type; p = 0; moves = 0;
      @(posedge clk); #1;
      bus.key = 4'hE;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (bus.filter_changed) p++;
         if (bus.filter_type !== ft0) moves++;
         bus.key = ((k + 1 < 10) || (k + 1 >= 13 && k + 1 < 23)) ? 4'hE : 4'hF;
      end
      n_checks++;
      if (p !== 0 || moves !== 0) $display("FAIL bounce_reject: got pulses=%0d moves=%0d want 0/0", p, moves);
      else n_pass++;
      drive_press(4'b0001, 20, fp, fa, cp, ca, cq, la, p, lm);
      model_apply(4'b0001);
      n_checks++;
      if (fa !== 2'(m_ft) || p !== 1) $display("FAIL clean_after_bounce: got ft=%0d pulses=%0d want %0d/1", fa, p, m_ft);
      else n_pass++;
   endtask

   task automatic test_lock();
      logic [3:0] seq [5];
      logic [1:0] fp, fa; logic cp, ca, cq, la; int p, lm, old;
      seq = '{4'b0001, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
      for (int i = 0; i < 5; i++) begin
         old = m_ft;
         drive_press(seq[i], D + 8, fp, fa, cp, ca, cq, la, p, lm);
         model_apply(seq[i]);
         n_checks++;
         if (fa !== 2'(m_ft) || la !== 1'(m_lock) || p !== ((m_ft != old) ? 1 : 0))
            $display("FAIL lock_step%0d: got ft=%0d lk=%0b pulses=%0d want %0d/%0d/%0d",
                     i, fa, la, p, m_ft, m_lock, (m_ft != old) ? 1 : 0);
         else n_pass++;
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] fp, fa; logic cp, ca, cq, la; int p, lm;
      while (m_ft != 2) begin
         drive_press(4'b0001, D + 6, fp, fa, cp, ca, cq, la, p, lm);
         model_apply(4'b0001);
      end
      n_checks++;
      if (bus.filter_type !== 2'd2) $display("FAIL simul_setup: got %0d want 2", bus.filter_type);
      else n_pass++;
      drive_press(4'b0101, D + 6, fp, fa, cp, ca, cq, la, p, lm);
      model_apply(4'b0101);
      n_checks++;
      if (fa !== 2'd0 || p !== 1) $display("FAIL clear_wins: got ft=%0d pulses=%0d want 0/1", fa, p);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] m;
      logic [1:0] fp, fa; logic cp, ca, cq, la; int p, lm, old;
      for (int i = 0; i < 12; i++) begin
         m   = 4'($urandom_range(1, 15));
         old = m_ft;
         drive_press(m, $urandom_range(D + 5, D + 25), fp, fa, cp, ca, cq, la, p, lm);
         model_apply(m);
         n_checks++;
         if (fa !== 2'(m_ft) || la !== 1'(m_lock))
            $display("FAIL rand%0d_state: mask=%b got ft=%0d lk=%0b want %0d/%0d", i, m, fa, la, m_ft, m_lock);
         else n_pass++;
         n_checks++;
         if (p !== ((m_ft != old) ? 1 : 0) || fp !== 2'(old) || lm !== 0)
            $display("FAIL rand%0d_pulse: mask=%b got pulses=%0d pre=%0d moves=%0d want %0d/%0d/0",
                     i, m, p, fp, lm, (m_ft != old) ? 1 : 0, old);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] fp, fa; logic cp, ca, cq, la; int p, lm;
      if (m_lock != 0) begin drive_press(4'b1000, D + 6, fp, fa, cp, ca, cq, la, p, lm); model_apply(4'b1000); end
      while (m_ft == 0) begin drive_press(4'b0001, D + 6, fp, fa, cp, ca, cq, la, p, lm); model_apply(4'b0001); end
      drive_press(4'b1000, D + 6, fp, fa, cp, ca, cq, la, p, lm);
      model_apply(4'b1000);
      @(posedge clk); #1;
      bus.key = 4'hE;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.filter_type, bus.filter_changed, bus.locked} !== 4'b0000)
         $display("FAIL reset_async: got ft=%0d chg=%0b lk=%0b want 0/0/0",
                  bus.filter_type, bus.filter_changed, bus.locked);
      else n_pass++;
      m_ft = 0; m_lock = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      fp = 2'd3; fa = 2'd0; ca = 1'b0; p = 0;
      for (int k = 0; k < D + 12; k++) begin
         @(posedge clk); #1;
         if (bus.filter_changed) p++;
         if (k == D + 2) fp = bus.filter_type;
         if (k == D + 3) begin fa = bus.filter_type; ca = bus.filter_changed; end
      end
      bus.key = 4'hF;
      model_apply(4'b0001);
      n_checks++;
      if (fp !== 2'd0 || fa !== 2'(m_ft) || ca !== 1'b1 || p !== 1)
         $display("FAIL held_through_reset: got pre=%0d ft=%0d chg=%0b pulses=%0d want 0/%0d/1/1", fp, fa, ca, p, m_ft);
      else n_pass++;
      repeat (D + 8) @(posedge clk);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; m_ft = 0; m_lock = 0;
      rst_n = 1'b0;
      bus.key = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      test_reset();
      test_latency();
      test_next_prev();
      test_bounce();
      test_lock();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
